// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the BCD seven-segment scanner: digit slots,
// active-low segment encodings and nibble selection helpers.
package bcd_display_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;

    // Bit-slice positions of each digit inside the packed time word
    localparam int unsigned SEC0_LSB = 0;
    localparam int unsigned SEC1_LSB = 4;
    localparam int unsigned MIN0_LSB = 8;
    localparam int unsigned MIN1_LSB = 12;

    typedef enum logic [1:0] {
        DIG_SEC0 = 2'd0,
        DIG_SEC1 = 2'd1,
        DIG_MIN0 = 2'd2,
        DIG_MIN1 = 2'd3
    } digit_e;

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = '1;
    localparam logic [3:0] AN_OFF   = '1;

    function automatic logic [NIBBLE_W-1:0] digit_nibble(input logic [15:0] word,
                                                         input digit_e    sel);
        case (sel)
            DIG_SEC0: return word[SEC0_LSB +: NIBBLE_W];
            DIG_SEC1: return word[SEC1_LSB +: NIBBLE_W];
            DIG_MIN0: return word[MIN0_LSB +: NIBBLE_W];
            default:  return word[MIN1_LSB +: NIBBLE_W];
        endcase
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_onehot_low(input digit_e sel);
        return ~(NUM_DIGITS'(1) << sel);
    endfunction

endpackage

// File: rtl/bcd_display_scan_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9
// render as a dash.
module bcd_to_seg
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed MM:SS display driver with frame-aligned snapshot.
// Optional LEAD_ZERO_BLANK_EN blanks a leading zero in the min_1 slot.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] big_bin,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned      DIV_W   = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    digit_e           idx;
    logic [15:0]      snap;
    logic             primed;
    logic             tick;
    logic             lead_blank;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;

    assign tick = (div_cnt == DIV_MAX);

    always_comb begin
        cur_nibble = digit_nibble(snap, idx);
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_nibble),
        .seg (cur_seg)
    );

`ifdef LEAD_ZERO_BLANK_EN
    assign lead_blank = (idx == DIG_MIN1) && (snap[MIN1_LSB +: NIBBLE_W] == 4'd0);
`else
    assign lead_blank = 1'b0;
`endif

    // The priming cycle only captures the snapshot; the scan starts counting
    // afterwards so digit 0 gets its full REFRESH_DIV slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            idx     <= DIG_SEC0;
            snap    <= '0;
            primed  <= 1'b0;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
            dp      <= 1'b1;
        end else if (!primed) begin
            primed <= 1'b1;
            snap   <= big_bin;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                idx     <= digit_e'(idx + 2'd1);
                if (idx == DIG_MIN1)
                    snap <= big_bin;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            an  <= (blank || lead_blank) ? AN_OFF : an_onehot_low(idx);
            seg <= cur_seg;
            dp  <= (idx != DIG_MIN0);
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed table-driven bench for bcd_display_scan with REFRESH_DIV=4.
module tb_bcd_display_scan;

    logic        clock;
    logic        reset_n;
    logic [15:0] big_bin;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int unsigned checks = 0;
    int unsigned errors = 0;

    bcd_display_scan #(.REFRESH_DIV(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .big_bin (big_bin),
        .blank   (blank),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned adv;
        logic [15:0] big;
        logic        blk;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           SD = 7'b0111111, SOFF = 7'b1111111;

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [3:0] AN_LEAD0 = 4'b1111;
`else
    localparam logic [3:0] AN_LEAD0 = 4'b0111;
`endif

    task automatic add(input int unsigned adv, input logic [15:0] big, input logic blk,
                       input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp,
                       input string name);
        vec_t v;
        v.adv = adv; v.big = big; v.blk = blk;
        v.e_an = e_an; v.e_seg = e_seg; v.e_dp = e_dp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] e_an,
                         input logic [6:0] e_seg, input logic e_dp);
        checks++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    task automatic advance(input int unsigned n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        big_bin = 16'h1234;
        blank   = 1'b0;

        // Cycle counts below are edges since reset release
        add(1, 16'h1234, 0, 4'b1111, SOFF, 1, "c1_priming");
        add(1, 16'h1234, 0, 4'b1110, S4,   1, "c2_digit0");
        add(3, 16'h1234, 0, 4'b1110, S4,   1, "c5_digit0_last");
        add(1, 16'h1234, 0, 4'b1101, S3,   1, "c6_digit1");
        add(1, 16'h5678, 0, 4'b1101, S3,   1, "c7_midframe_change");
        add(3, 16'h5678, 0, 4'b1011, S2,   0, "c10_digit2_colon");
        add(4, 16'h5678, 0, 4'b0111, S1,   1, "c14_digit3");
        add(3, 16'h5678, 0, 4'b0111, S1,   1, "c17_digit3_last");
        add(1, 16'h5678, 0, 4'b1110, S8,   1, "c18_new_frame_d0");
        add(4, 16'h5678, 0, 4'b1101, S7,   1, "c22_new_frame_d1");
        add(4, 16'h5678, 0, 4'b1011, S6,   0, "c26_new_frame_d2");
        add(4, 16'h5678, 0, 4'b0111, S5,   1, "c30_new_frame_d3");
        add(2, 16'h5678, 0, 4'b0111, S5,   1, "c32_before_tick");
        add(1, 16'h0A00, 0, 4'b0111, S5,   1, "c33_tick_cycle_change");
        add(1, 16'h1234, 0, 4'b1110, S0,   1, "c34_captured_on_tick");
        add(4, 16'h1234, 0, 4'b1101, S0,   1, "c38_0A00_d1");
        add(4, 16'h1234, 0, 4'b1011, SD,   0, "c42_invalid_dash");
        add(4, 16'h1234, 0, AN_LEAD0, S0,  1, "c46_leading_zero");
        add(3, 16'h1234, 0, AN_LEAD0, S0,  1, "c49_leading_zero_last");
        add(1, 16'h1234, 0, 4'b1110, S4,   1, "c50_digit0");
        add(1, 16'h1234, 1, 4'b1111, S4,   1, "c51_blank1");
        add(1, 16'h1234, 1, 4'b1111, S4,   1, "c52_blank2");
        add(1, 16'h1234, 1, 4'b1111, S4,   1, "c53_blank3");
        add(1, 16'h1234, 0, 4'b1101, S3,   1, "c54_after_blank");
        add(4, 16'h1234, 0, 4'b1011, S2,   0, "c58_phase_kept");

        repeat (2) @(negedge clock);
        check("in_reset", 4'b1111, SOFF, 1'b1);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            big_bin = vecs[i].big;
            blank   = vecs[i].blk;
            advance(vecs[i].adv);
            check(vecs[i].name, vecs[i].e_an, vecs[i].e_seg, vecs[i].e_dp);
        end

        // Asynchronous reset mid-digit, then restart with a fresh snapshot
        big_bin = 16'h9876;
        #2 reset_n = 1'b0;
        #1 check("async_reset_no_edge", 4'b1111, SOFF, 1'b1);
        advance(2);
        check("held_in_reset", 4'b1111, SOFF, 1'b1);
        reset_n = 1'b1;
        advance(1);
        check("rst2_priming", 4'b1111, SOFF, 1'b1);
        advance(1);
        check("rst2_digit0", 4'b1110, S6, 1'b1);
        advance(4);
        check("rst2_digit1", 4'b1101, S7, 1'b1);
        advance(4);
        check("rst2_digit2", 4'b1011, S8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Consumer of the packed 16-bit BCD time word (`{min_1, min_0, sec_1, sec_0}`) produced by the timer's counter path. It unpacks the word into four digits and time-multiplexes them onto a 4-digit common-anode seven-segment display, with a colon (decimal point) between minutes and seconds. A frame-aligned snapshot of the input prevents tearing mid-scan. It sits between the counter/concatenation stage and the board display pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit is driven (1 kHz per digit at 100 MHz); legal range ≥ 2.
- `clock` input 1: system clock, same clock as the counter.
- `reset_n` input 1: asynchronous, active-low reset.
- `big_bin` input 16: packed BCD; [15:12] min_1, [11:8] min_0, [7:4] sec_1, [3:0] sec_0.
- `blank` input 1: when high, all anodes off.
- `an` output 4: active-low digit enables; an[0] = sec_0 … an[3] = min_1.
- `seg` output 7: active-low segments {g,f,e,d,c,b,a}.
- `dp` output 1: active-low decimal point (colon).

Clock is single; reset is asynchronous active-low, no other reset.

## Operation
- Prescaler `div_cnt` counts 0..REFRESH_DIV-1 and wraps; `tick` = (div_cnt == REFRESH_DIV-1).
- 2-bit digit index `idx` increments on `tick`, wrapping 3→0.
- Snapshot register `snap` loads `big_bin` when `tick && idx==3` (frame start). It also loads on the first clock after reset release, via a `primed` flag cleared by reset and set on that load.
- Digit select: idx0→snap[3:0], idx1→snap[7:4], idx2→snap[11:8], idx3→snap[15:12].
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 (invalid BCD) = 0111111 (dash, g only).
- `an` = one-hot-low of idx, e.g. idx2 → 4'b1011. `blank` high forces `an`=4'b1111; `seg`/`dp` are still driven but ignored.
- `dp` low only when idx==2; otherwise high.

## Timing
- Reset values: div_cnt=0, idx=0, snap=0, primed=0, an=4'b1111, seg=7'b1111111, dp=1.
- `an`/`seg`/`dp` are registered: they reflect idx/snap/blank of the previous cycle (1-cycle latency).
  - First cycle after reset release: outputs still at reset values.
  - Second cycle: digit 0 of snap, which was loaded from `big_bin` on the first cycle.
- Each digit is held exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- `big_bin` changes mid-frame are invisible until the next frame start. A change in the same cycle as the frame-start tick is captured.
- `blank` takes effect 1 cycle after assertion and does not disturb div_cnt, idx or snap.
- Reset mid-frame immediately returns all state and outputs to reset values.

## Configuration
- `LEAD_ZERO_BLANK_EN` defined: when idx==3 and snap[15:12]==0, `an` stays 4'b1111 for that digit slot; timing is unchanged.
- `LEAD_ZERO_BLANK_EN` undefined: min_1 is always displayed, including 0.

## Structure
- Shared package holds:
  - the seven-segment encoding constants (digits 0–9 and the dash);
  - `NUM_DIGITS`=4 and the `idx`→nibble bit-slice positions.
- One combinational sub-module, `bcd_to_seg` (4-bit BCD in, 7-bit active-low segments out, dash for >9).
- Prescaler, index, snapshot and output registers stay in the top level.

## Test plan
- Reset, REFRESH_DIV=4, big_bin=16'h1234:
  - cycle 1: an=1111;
  - cycle 2: an=1110, seg=0011001 (4);
  - after 4 more cycles: an=1101, seg=0110000 (3);
  - then an=1011, dp=0 (2), then an=0111 (1).
- Change big_bin from 16'h1234 to 16'h5678 during idx1: the remaining digits of that frame show 2,1; the next frame shows 8,7,6,5.
- big_bin=16'h0A00: idx2 slot shows seg=0111111 (dash). With LEAD_ZERO_BLANK_EN, the idx3 slot has an=1111; without it, seg=1000000 (0).
- blank pulsed high for 3 cycles mid-digit: an=1111 for exactly those 3 cycles, delayed by 1; the scan phase is unchanged afterward.
- reset_n asserted mid-frame: outputs go to 1111/1111111/1 with no clock edge. After release, the scan restarts at digit 0 with a fresh snapshot.
